// File: rtl/mux_rr_nw_pkg.sv
// mux_rr_nw_pkg: shared definitions for the round-robin output multiplexer.
//   - default channel count and data width
//   - arbiter lock state encoding
//   - round-robin pointer increment helper (wraps at n-1, so n need not be a power of 2)
package mux_rr_nw_pkg;

    localparam int N_CH_DEF = 4;
    localparam int W_DEF    = 8;

    // FREE: grant is decided per beat. LOCKED: grant is held on one channel until its last beat.
    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Channel that follows g in round-robin order among n channels.
    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mux_rr_nw_if.sv
// mux_rr_nw_if: producer/consumer bundle of the round-robin multiplexer.
//   in_valid  [N_CH]    per-channel valid          (producer -> mux)
//   in_data   [N_CH*W]  channel i at [i*W +: W]    (producer -> mux)
//   in_ready  [N_CH]    per-channel ready          (mux -> producer)
//   out_valid           output register holds a beat
//   out_data  [W]       registered data
//   out_sel   [SW]      channel that produced out_data
//   out_ready           consumer accepts
// With MUX_RR_LOCK_EN defined, in_last [N_CH] and out_last are added.
// Modports: slave = the multiplexer, master = the surrounding producers/consumer.
interface mux_rr_nw_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
);
    localparam int SW = $clog2(N_CH);

    logic [N_CH-1:0]   in_valid;
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_sel;
    logic              out_ready;
`ifdef MUX_RR_LOCK_EN
    logic [N_CH-1:0]   in_last;
    logic              out_last;

    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_data, out_sel, out_last);
    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_data, out_sel, out_last);
`else
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_sel);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_sel);
`endif
endinterface

// File: rtl/mux_rr_nw_arbiter.sv
// rr_arbiter: round-robin arbiter with optional grant lock.
//   clk, rst  clock, synchronous active-high reset
//   req_i     per-channel request (in_valid)
//   adv_i     a beat from the granted channel was accepted this cycle
//   last_i    the accepted beat closes the packet (tie high for per-beat arbitration)
//   grant_o   one-hot grant, zero when nothing eligible requests
//   gidx_o    index of the granted channel
// Holds the round-robin pointer and the lock state.
module rr_arbiter
    import mux_rr_nw_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           req_i,
    input  logic                      adv_i,
    input  logic                      last_i,
    output logic [N_CH-1:0]           grant_o,
    output logic [$clog2(N_CH)-1:0]   gidx_o
);
    localparam int SW = $clog2(N_CH);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] lidx_q, lidx_d;

    logic [SW:0]   pos;
    logic [SW-1:0] cand;
    logic          found;

    // Grant: locked channel only (and only while it requests), otherwise the
    // first requester scanning ptr, ptr+1, ... with wrap at N_CH-1.
    always_comb begin
        grant_o = '0;
        gidx_o  = '0;
        found   = 1'b0;
        pos     = '0;
        cand    = '0;
        if (state_q == ARB_LOCKED) begin
            if (req_i[lidx_q]) begin
                grant_o[lidx_q] = 1'b1;
                gidx_o          = lidx_q;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                pos = {1'b0, ptr_q} + (SW+1)'(k);
                if (pos >= (SW+1)'(N_CH)) begin
                    pos = pos - (SW+1)'(N_CH);
                end
                cand = pos[SW-1:0];
                if (!found && req_i[cand]) begin
                    found         = 1'b1;
                    grant_o[cand] = 1'b1;
                    gidx_o        = cand;
                end
            end
        end
    end

    // Pointer moves past the winner only when its packet closes.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lidx_d  = lidx_q;
        if (adv_i) begin
            if (last_i) begin
                state_d = ARB_FREE;
                ptr_d   = SW'(rr_next(int'(gidx_o), N_CH));
            end else begin
                state_d = ARB_LOCKED;
                lidx_d  = gidx_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_FREE;
            ptr_q   <= '0;
            lidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lidx_q  <= lidx_d;
        end
    end

endmodule

// File: rtl/mux_rr_nw.sv
// mux_rr_nw: N_CH-channel, W-bit registered multiplexer with round-robin
// arbitration and valid/ready handshake on both sides.
//   clk   single clock, rising edge
//   rst   synchronous reset, active-high
//   bus   mux_rr_nw_if.slave (in_valid/in_data/in_ready, out_valid/out_data/out_sel/out_ready)
// Optional macro MUX_RR_LOCK_EN: adds in_last/out_last; a multi-beat packet
// keeps the grant until its last beat is accepted.
// out_ready -> in_ready is a combinational path; in_valid never reaches out_* combinationally.
module mux_rr_nw
    import mux_rr_nw_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int W    = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mux_rr_nw_if.slave   bus
);
    localparam int SW = $clog2(N_CH);

    logic [N_CH-1:0] grant;
    logic [SW-1:0]   gidx;
    logic            can_acc;
    logic            load;
    logic            beat_last;
    logic [W-1:0]    data_sel;

    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [SW-1:0]   out_sel_q;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (bus.in_valid),
        .adv_i   (load),
        .last_i  (beat_last),
        .grant_o (grant),
        .gidx_o  (gidx)
    );

    // Output register is free, or being drained this cycle.
    assign can_acc = !out_valid_q || bus.out_ready;
    assign load    = can_acc && (|grant) && !rst;
    // Held low in reset so no producer sees a beat accepted that reset discards.
    assign bus.in_ready = grant & {N_CH{can_acc && !rst}};

    // AND-OR select: only the granted (valid) channel contributes, so X on idle channels stays out.
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                data_sel = bus.in_data[i*W +: W];
            end
        end
    end

`ifdef MUX_RR_LOCK_EN
    logic out_last_q;
    assign beat_last    = |(grant & bus.in_last);
    assign bus.out_last = out_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_last_q <= 1'b0;
        end else if (load) begin
            out_last_q <= beat_last;
        end
    end
`else
    assign beat_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= data_sel;
            out_sel_q   <= gidx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule
